// File: rtl/usb_rx_decoder.sv
// USB full-speed receive decoder: NRZI decode, SYNC detect, bit unstuffing, byte assembly, EOP detect.
// Optional macro USB_RX_STICKY_ERR_EN turns rx_error into a level cleared only by rst or rx_start.
module usb_rx_decoder #(
    parameter int unsigned STUFF_LEN      = 6,
    parameter int unsigned SYNC_MIN_ZEROS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp,
    input  logic       dm,
    input  logic       shift_enable,
    input  logic       rx_start,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       sync_done,
    output logic       eop_pulse,
    output logic       rx_error,
    output logic       disable_timer
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP1 = 3'd3,
        ST_EOP2 = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                prev_dp_q, prev_dp_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic [BYTE_W-1:0]   shift_reg_q, shift_reg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    ones_cnt_q, ones_cnt_d;
    logic [CNT_W-1:0]    zero_cnt_q, zero_cnt_d;
    logic                valid_q, valid_d;
    logic                sync_done_q, sync_done_d;
    logic                eop_q, eop_d;
    logic                rx_error_q, rx_error_d;
    logic                disable_timer_q, disable_timer_d;

    logic                se0_c;
    logic                line_j_c;
    logic                bit_c;
    logic                err_set_c;
    logic [BYTE_W-1:0]   shifted_c;

    assign se0_c     = ~dp & ~dm;
    assign line_j_c  = dp & ~dm;
    assign bit_c     = (dp == prev_dp_q);
    assign shifted_c = {bit_c, shift_reg_q[BYTE_W-1:1]};

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            prev_dp_q       <= 1'b1;
            rx_data_q       <= '0;
            shift_reg_q     <= '0;
            bit_cnt_q       <= '0;
            ones_cnt_q      <= '0;
            zero_cnt_q      <= '0;
            valid_q         <= 1'b0;
            sync_done_q     <= 1'b0;
            eop_q           <= 1'b0;
            rx_error_q      <= 1'b0;
            disable_timer_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            prev_dp_q       <= prev_dp_d;
            rx_data_q       <= rx_data_d;
            shift_reg_q     <= shift_reg_d;
            bit_cnt_q       <= bit_cnt_d;
            ones_cnt_q      <= ones_cnt_d;
            zero_cnt_q      <= zero_cnt_d;
            valid_q         <= valid_d;
            sync_done_q     <= sync_done_d;
            eop_q           <= eop_d;
            rx_error_q      <= rx_error_d;
            disable_timer_q <= disable_timer_d;
        end
    end

    // Next-state and output decode; rx_start restarts from any state and outranks a strobe
    always_comb begin
        state_d     = state_q;
        prev_dp_d   = prev_dp_q;
        rx_data_d   = rx_data_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        zero_cnt_d  = zero_cnt_q;
        valid_d     = 1'b0;
        sync_done_d = 1'b0;
        eop_d       = 1'b0;
        err_set_c   = 1'b0;

        if (rx_start) begin
            state_d     = ST_SYNC;
            prev_dp_d   = 1'b1;
            zero_cnt_d  = '0;
            ones_cnt_d  = '0;
            bit_cnt_d   = '0;
            shift_reg_d = '0;
        end else if (shift_enable) begin
            unique case (state_q)
                ST_SYNC: begin
                    if (se0_c) begin
                        err_set_c = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        prev_dp_d = dp;
                        if (!bit_c) begin
                            if (zero_cnt_q != {CNT_W{1'b1}}) begin
                                zero_cnt_d = zero_cnt_q + CNT_W'(1);
                            end
                        end else if (zero_cnt_q >= CNT_W'(SYNC_MIN_ZEROS)) begin
                            sync_done_d = 1'b1;
                            state_d     = ST_DATA;
                            ones_cnt_d  = CNT_W'(1);
                            bit_cnt_d   = '0;
                        end else begin
                            err_set_c = 1'b1;
                            state_d   = ST_ERR;
                        end
                    end
                end
                ST_DATA: begin
                    if (se0_c) begin
                        state_d   = ST_EOP1;
                        err_set_c = (bit_cnt_q != '0);
                        bit_cnt_d = '0;
                    end else begin
                        prev_dp_d = dp;
                        if (ones_cnt_q == CNT_W'(STUFF_LEN)) begin
                            // Stuff slot: a 0 is dropped, a 1 is a violation
                            if (!bit_c) begin
                                ones_cnt_d = '0;
                            end else begin
                                err_set_c = 1'b1;
                                state_d   = ST_ERR;
                            end
                        end else begin
                            shift_reg_d = shifted_c;
                            ones_cnt_d  = bit_c ? ones_cnt_q + CNT_W'(1) : '0;
                            if (bit_cnt_q == BIT_W'(BYTE_W - 1)) begin
                                rx_data_d = shifted_c;
                                valid_d   = 1'b1;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            end
                        end
                    end
                end
                ST_EOP1: begin
                    if (se0_c) begin
                        state_d = ST_EOP2;
                    end else begin
                        err_set_c = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_EOP2: begin
                    if (line_j_c) begin
                        eop_d     = 1'b1;
                        prev_dp_d = 1'b1;
                    end else begin
                        err_set_c = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                end
            endcase
        end

`ifdef USB_RX_STICKY_ERR_EN
        rx_error_d = rx_start ? 1'b0 : (rx_error_q | err_set_c);
`else
        rx_error_d = err_set_c;
`endif
        disable_timer_d = (state_d == ST_IDLE) || (state_d == ST_ERR);
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = valid_q;
    assign sync_done     = sync_done_q;
    assign eop_pulse     = eop_q;
    assign rx_error      = rx_error_q;
    assign disable_timer = disable_timer_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed self-checking bench for usb_rx_decoder (default build, pulse-mode rx_error).
module tb_usb_rx_decoder;

    logic       clk;
    logic       rst;
    logic       dp;
    logic       dm;
    logic       shift_enable;
    logic       rx_start;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       sync_done;
    logic       eop_pulse;
    logic       rx_error;
    logic       disable_timer;

    int checks;
    int failures;

    int valid_cnt;
    int sync_cnt;
    int eop_cnt;
    int err_cnt;

    logic tb_line;
    int   tb_ones;

    usb_rx_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .dp            (dp),
        .dm            (dm),
        .shift_enable  (shift_enable),
        .rx_start      (rx_start),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .sync_done     (sync_done),
        .eop_pulse     (eop_pulse),
        .rx_error      (rx_error),
        .disable_timer (disable_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle
    always @(negedge clk) begin
        if (rx_data_valid) valid_cnt++;
        if (sync_done)     sync_cnt++;
        if (eop_pulse)     eop_cnt++;
        if (rx_error)      err_cnt++;
    end

    // One strobe with given line levels; returns with that strobe's effects visible
    task automatic strobe(input logic d_p, input logic d_m);
        @(negedge clk);
        dp = d_p;
        dm = d_m;
        shift_enable = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0;
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_start = 1'b1;
        @(negedge clk);
        rx_start = 1'b0;
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (!b) tb_line = ~tb_line;
        strobe(tb_line, ~tb_line);
    endtask

    task automatic send_sync();
        pulse_start();
        strobe(0, 1); strobe(1, 0); strobe(0, 1); strobe(1, 0);
        strobe(0, 1); strobe(1, 0); strobe(0, 1); strobe(0, 1);
        tb_line = 1'b0;
        tb_ones = 1;
    endtask

    // LSB-first NRZI byte with a stuffed 0 after every six consecutive 1s
    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            tb_ones = b[i] ? tb_ones + 1 : 0;
            if (tb_ones == 6) begin
                send_bit(1'b0);
                tb_ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        strobe(0, 0);
        strobe(0, 0);
        strobe(1, 0);
        tb_line = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rx_data !== 8'h00) begin
            failures++; $display("FAIL reset_rx_data got=%h want=00", rx_data);
        end
        checks++;
        if (disable_timer !== 1'b1) begin
            failures++; $display("FAIL reset_disable_timer got=%b want=1", disable_timer);
        end
        checks++;
        if ({rx_data_valid, sync_done, eop_pulse, rx_error} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses got=%b want=0000", {rx_data_valid, sync_done, eop_pulse, rx_error});
        end
    endtask

    task automatic test_sync_byte();
        int v0, e0, p0;
        v0 = valid_cnt; e0 = err_cnt; p0 = eop_cnt;
        pulse_start();
        strobe(0, 1); strobe(1, 0); strobe(0, 1); strobe(1, 0);
        strobe(0, 1); strobe(1, 0); strobe(0, 1);
        checks++;
        if (sync_done !== 1'b0) begin
            failures++; $display("FAIL sync_early got=%b want=0", sync_done);
        end
        strobe(0, 1);
        checks++;
        if (sync_done !== 1'b1) begin
            failures++; $display("FAIL sync_done_timing got=%b want=1", sync_done);
        end
        checks++;
        if (disable_timer !== 1'b0) begin
            failures++; $display("FAIL sync_timer_enabled got=%b want=0", disable_timer);
        end
        // 8'hA5 LSB first is 1,0,1,0,0,1,0,1; NRZI from K gives dp 0,1,1,0,1,1,0,0
        strobe(0, 1); strobe(1, 0); strobe(1, 0); strobe(0, 1);
        strobe(1, 0); strobe(1, 0); strobe(0, 1); strobe(0, 1);
        checks++;
        if (rx_data !== 8'hA5 || rx_data_valid !== 1'b1) begin
            failures++; $display("FAIL a5_byte got=%h/%b want=a5/1", rx_data, rx_data_valid);
        end
        strobe(0, 0); strobe(0, 0); strobe(1, 0);
        tb_line = 1'b1;
        checks++;
        if (eop_pulse !== 1'b1 || disable_timer !== 1'b1) begin
            failures++; $display("FAIL a5_eop got=%b/%b want=1/1", eop_pulse, disable_timer);
        end
        checks++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0 || eop_cnt - p0 !== 1) begin
            failures++;
            $display("FAIL a5_counts valid=%0d err=%0d eop=%0d want=1/0/1", valid_cnt - v0, err_cnt - e0, eop_cnt - p0);
        end
    endtask

    task automatic test_bit_stuff();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_sync();
        send_byte(8'hFF);
        checks++;
        if (rx_data !== 8'hFF) begin
            failures++; $display("FAIL stuff_ff_data got=%h want=ff", rx_data);
        end
        send_eop();
        checks++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
            failures++; $display("FAIL stuff_ff_counts valid=%0d err=%0d want=1/0", valid_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_stuff_violation();
        int v0, e0;
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        e0 = err_cnt;
        send_bit(1'b1);
        checks++;
        if (rx_error !== 1'b1 || disable_timer !== 1'b1) begin
            failures++; $display("FAIL stuff_violation got=%b/%b want=1/1", rx_error, disable_timer);
        end
        v0 = valid_cnt;
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        strobe(0, 0);
        checks++;
        if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0 || disable_timer !== 1'b1) begin
            failures++;
            $display("FAIL err_state_ignores err=%0d valid=%0d timer=%b want=1/0/1", err_cnt - e0, valid_cnt - v0, disable_timer);
        end
        pulse_start();
        checks++;
        if (disable_timer !== 1'b0) begin
            failures++; $display("FAIL err_exit_on_start got=%b want=0", disable_timer);
        end
    endtask

    task automatic test_partial_eop();
        int v0, e0, p0;
        send_sync();
        v0 = valid_cnt; p0 = eop_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        e0 = err_cnt;
        strobe(0, 0);
        checks++;
        if (rx_error !== 1'b1) begin
            failures++; $display("FAIL partial_err got=%b want=1", rx_error);
        end
        strobe(0, 0); strobe(1, 0);
        tb_line = 1'b1;
        checks++;
        if (eop_pulse !== 1'b1 || rx_data !== 8'hFF) begin
            failures++; $display("FAIL partial_eop got=%b/%h want=1/ff", eop_pulse, rx_data);
        end
        checks++;
        if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 1 || eop_cnt - p0 !== 1) begin
            failures++;
            $display("FAIL partial_counts valid=%0d err=%0d eop=%0d want=0/1/1", valid_cnt - v0, err_cnt - e0, eop_cnt - p0);
        end
    endtask

    task automatic test_short_sync();
        int s0;
        s0 = sync_cnt;
        pulse_start();
        strobe(0, 1); strobe(1, 0); strobe(0, 1); strobe(0, 1);
        checks++;
        if (rx_error !== 1'b1 || disable_timer !== 1'b1 || sync_cnt - s0 !== 0) begin
            failures++;
            $display("FAIL short_sync err=%b timer=%b syncs=%0d want=1/1/0", rx_error, disable_timer, sync_cnt - s0);
        end
    endtask

    task automatic test_reset_mid_byte();
        send_sync();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rx_data !== 8'h00 || disable_timer !== 1'b1 ||
            {rx_data_valid, sync_done, eop_pulse, rx_error} !== 4'b0000) begin
            failures++; $display("FAIL mid_reset got=%h/%b want=00/1", rx_data, disable_timer);
        end
        send_sync();
        send_byte(8'h3C);
        checks++;
        if (rx_data !== 8'h3C) begin
            failures++; $display("FAIL post_reset_byte got=%h want=3c", rx_data);
        end
        send_eop();
    endtask

    // 8'hFC ends on six 1s, so its stuff slot falls on the next strobe
    task automatic test_back_to_back();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_sync();
        send_byte(8'hFC);
        checks++;
        if (rx_data !== 8'hFC) begin
            failures++; $display("FAIL b2b_first got=%h want=fc", rx_data);
        end
        send_byte(8'h01);
        checks++;
        if (rx_data !== 8'h01) begin
            failures++; $display("FAIL b2b_second got=%h want=01", rx_data);
        end
        send_eop();
        checks++;
        if (valid_cnt - v0 !== 2 || err_cnt - e0 !== 0) begin
            failures++; $display("FAIL b2b_counts valid=%0d err=%0d want=2/0", valid_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_restart();
        int e0;
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        e0 = err_cnt;
        send_sync();
        send_byte(8'h5A);
        send_eop();
        checks++;
        if (rx_data !== 8'h5A || err_cnt - e0 !== 0) begin
            failures++; $display("FAIL restart got=%h err=%0d want=5a/0", rx_data, err_cnt - e0);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        valid_cnt = 0; sync_cnt = 0; eop_cnt = 0; err_cnt = 0;
        tb_line = 1'b1; tb_ones = 0;
        rst = 1'b1; dp = 1'b1; dm = 1'b0; shift_enable = 1'b0; rx_start = 1'b0;
        test_reset();
        test_sync_byte();
        test_bit_stuff();
        test_stuff_violation();
        test_partial_eop();
        test_short_sync();
        test_reset_mid_byte();
        test_back_to_back();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
- Downstream consumer of the RX bit timer.
- On every `shift_enable` strobe it samples the synchronized D+/D- lines and performs:
  - NRZI decode,
  - SYNC detection,
  - bit unstuffing,
  - LSB-first byte assembly and EOP detection.
- Emits assembled bytes to the RX packet controller.
- Drives `disable_timer` back to the timer so the byte timer idles between packets and after errors.

Parameters:
- STUFF_LEN, 6: consecutive decoded 1s after which a stuffed 0 is expected and dropped.
- SYNC_MIN_ZEROS, 5: minimum decoded 0s required before the terminating 1 of SYNC is accepted.

Ports:
- clk, input, 1: system clock, all state on rising edge.
- rst, input, 1: reset, synchronous, active-high.
- dp, input, 1: synchronized D+ line.
- dm, input, 1: synchronized D- line.
- shift_enable, input, 1: one-cycle bit-sample strobe from the timer.
- rx_start, input, 1: one-cycle pulse on first line activity (first J->K edge) of a packet.
- rx_data, output, 8: last completed byte, held until the next byte completes.
- rx_data_valid, output, 1: one-cycle pulse when `rx_data` updates.
- sync_done, output, 1: one-cycle pulse when SYNC is recognised.
- eop_pulse, output, 1: one-cycle pulse on a valid EOP.
- rx_error, output, 1: one-cycle pulse on any receive error.
- disable_timer, output, 1: high in IDLE and ERR states.

Behaviour:
- Reset (sync, `rst=1`):
  - state=IDLE, `prev_dp=1` (J), `rx_data=8'h00`, all pulses 0, `disable_timer=1`.
  - ones_cnt=0, bit_cnt=0, zero_cnt=0, shift_reg=0.
  - `rst` dominates all other inputs.
- All outputs are registered. Effects of a strobe appear the cycle after the `shift_enable` cycle. No activity occurs on cycles without `shift_enable` except `rx_start` handling.
- SE0 means `dp=0 & dm=0` at the strobe.
- NRZI decode (non-SE0 strobe): `bit = (dp == prev_dp)`, then `prev_dp <= dp`. `prev_dp` is not updated on SE0.
- States and transitions:
  - IDLE: on `rx_start`, go to SYNC with zero_cnt=0 and `prev_dp=1`.
  - SYNC, decoded 0: zero_cnt++ (saturating at 15).
  - SYNC, decoded 1:
    - if zero_cnt ≥ SYNC_MIN_ZEROS: pulse `sync_done`, go to DATA with ones_cnt=1, bit_cnt=0;
    - otherwise: `rx_error`, go to ERR.
  - SYNC, SE0: `rx_error`, go to IDLE.
  - DATA, decoded bit with ones_cnt < STUFF_LEN:
    - shift_reg <= {bit, shift_reg[7:1]} (LSB first);
    - bit_cnt++;
    - ones_cnt <= bit ? ones_cnt+1 : 0.
  - DATA, ones_cnt == STUFF_LEN (stuff slot):
    - decoded 0: dropped, not shifted, bit_cnt unchanged, ones_cnt=0;
    - decoded 1: `rx_error`, go to ERR.
  - DATA, 8th bit shifted: `rx_data <= {bit, shift_reg[7:1]}`, pulse `rx_data_valid`, bit_cnt=0. A byte completing and a stuff slot in the following strobe are both legal.
  - DATA, SE0: go to EOP1. If bit_cnt≠0 (partial byte), also pulse `rx_error`; the partial byte is discarded.
  - EOP1: SE0 goes to EOP2; anything else gives `rx_error` and goes to IDLE.
  - EOP2:
    - J (`dp=1, dm=0`): pulse `eop_pulse`, `prev_dp<=1`, go to IDLE;
    - SE0 or K: `rx_error`, go to IDLE.
  - ERR: ignores strobes; leaves only on `rx_start` (to SYNC).
- `rx_start` in SYNC/DATA/EOP1/EOP2 restarts to SYNC with no error pulse; an in-progress byte is discarded.
- Counter widths:
  - bit_cnt: 3 bits plus done logic, or 4 bits.
  - ones_cnt and zero_cnt: 4 bits.

Optional Feature:
- Macro `USB_RX_STICKY_ERR_EN`.
- Defined: `rx_error` is a level. It sets on any error condition and clears only on `rst` or on `rx_start`. `rx_start` has priority over a same-cycle set.
- Undefined: `rx_error` is the one-cycle pulse described above.

Test Plan:
- SYNC plus one byte:
  - stimulus: line K,J,K,J,K,J,K,K (dp=0,1,0,1,0,1,0,0), then the NRZI encoding of 8'hA5, then SE0,SE0,J, all on strobes;
  - response: `sync_done` one cycle after the 8th SYNC strobe; `rx_data=8'hA5` with one `rx_data_valid` pulse; `eop_pulse`; `disable_timer` returns to 1.
- Bit stuffing:
  - stimulus: byte 8'hFF transmitted with a stuffed 0 after six 1s;
  - response: `rx_data=8'hFF`, valid pulses exactly once, no `rx_error`.
- Stuff violation:
  - stimulus: seven consecutive decoded 1s in DATA;
  - response: `rx_error` pulse, state ERR, `disable_timer=1`, later strobes ignored until `rx_start`.
- Partial byte at EOP:
  - stimulus: SE0 after 3 data bits;
  - response: `rx_error` pulse, no `rx_data_valid`, `rx_data` unchanged; EOP still completes with an `eop_pulse`.
- Short SYNC:
  - stimulus: `rx_start`, then decoded 0,0,0,1;
  - response: `rx_error`, state ERR, no `sync_done`.
- Reset mid-byte:
  - stimulus: `rst` asserted for one cycle after 4 data bits;
  - response: next cycle `rx_data=8'h00`, `disable_timer=1`, all pulses 0; a following full packet decodes correctly.
